// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor.
// Counter state encodings, reset value and the EX slot bundle.
package bp_pkg;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   localparam logic [1:0] CTR_RST = WNT;

   // Widest table index the slot can carry.
   localparam int IDX_W_MAX = 8;

   typedef struct packed {
      logic                 valid;
      logic                 pred;
      logic [IDX_W_MAX-1:0] idx;
      logic [31:0]          target;
      logic [31:0]          pc4;
   } bp_ex_slot_t;

endpackage

// File: rtl/branch_predictor_if.sv
// Pipeline-facing bundle of the branch predictor.
// master: pipeline (drives ID/EX info), slave: predictor.
interface branch_predictor_if #(
   parameter int CNT_W = 16
);
   logic             stall;
   logic             id_branch;
   logic [31:0]      id_pc;
   logic [31:0]      id_pc_imm;
   logic             ex_taken;
   logic             branch_o;
   logic             miss_o;
   logic [31:0]      recover_pc_o;
   logic [CNT_W-1:0] br_cnt_o;
   logic [CNT_W-1:0] miss_cnt_o;

   modport master (
      output stall, id_branch, id_pc, id_pc_imm, ex_taken,
      input  branch_o, miss_o, recover_pc_o,
      input  br_cnt_o, miss_cnt_o
   );

   modport slave (
      input  stall, id_branch, id_pc, id_pc_imm, ex_taken,
      output branch_o, miss_o, recover_pc_o,
      output br_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/bp_counter_table.sv
// Table of 2-bit saturating counters, async read, sync write.
// Ports: clk, rst, rd_idx_i/rd_ctr_o, we_i/wr_idx_i/taken_i.
module bp_counter_table
   import bp_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic [1:0]       rd_ctr_o,
   input  logic             we_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             taken_i
);
   localparam int N = 2 ** IDX_W;

   logic [1:0] ctr_q [N];
   logic [1:0] cur;
   logic [1:0] ctr_d;

   // Read returns the pre-update value on a same-entry write.
   assign rd_ctr_o = ctr_q[rd_idx_i];
   assign cur      = ctr_q[wr_idx_i];

   always_comb begin
      ctr_d = cur;
      if (taken_i) begin
         if (cur != ST) ctr_d = cur + 2'd1;
      end else begin
         if (cur != SNT) ctr_d = cur - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) ctr_q[i] <= CTR_RST;
      end else if (we_i) begin
         ctr_q[wr_idx_i] <= ctr_d;
      end
   end
endmodule

// File: rtl/branch_predictor.sv
// Branch predictor: ID lookup, EX slot, resolve, statistics.
// Ports: clk, rst, bp (slave modport of branch_predictor_if).
module branch_predictor
   import bp_pkg::*;
#(
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   branch_predictor_if.slave  bp
);
   bp_ex_slot_t      slot_q, slot_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
   logic [1:0]       rd_ctr;
   logic             miss;
   logic             resolve;

   bp_counter_table #(
      .IDX_W (IDX_W)
   ) u_tbl (
      .clk      (clk),
      .rst      (rst),
      .rd_idx_i (bp.id_pc[IDX_W+1:2]),
      .rd_ctr_o (rd_ctr),
      .we_i     (resolve),
      .wr_idx_i (slot_q.idx[IDX_W-1:0]),
      .taken_i  (bp.ex_taken)
   );

   // An in-flight branch is dropped while reset is asserted.
   assign miss    = slot_q.valid & ~rst & (slot_q.pred != bp.ex_taken);
   assign resolve = slot_q.valid & ~rst & ~bp.stall;

   assign bp.miss_o       = miss;
   assign bp.branch_o     = bp.id_branch & ~miss & ~rst & rd_ctr[1];
   assign bp.recover_pc_o = !miss        ? 32'h0 :
                            bp.ex_taken  ? slot_q.target : slot_q.pc4;
   assign bp.br_cnt_o     = br_cnt_q;
   assign bp.miss_cnt_o   = miss_cnt_q;

   always_comb begin
      slot_d        = slot_q;
      br_cnt_d      = br_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      if (!bp.stall) begin
         slot_d.valid  = bp.id_branch & ~miss;
         slot_d.pred   = rd_ctr[1];
         slot_d.idx    = IDX_W_MAX'(bp.id_pc[IDX_W+1:2]);
         slot_d.target = bp.id_pc_imm;
         slot_d.pc4    = bp.id_pc + 32'd4;
      end
      if (resolve) begin
         br_cnt_d = br_cnt_q + CNT_W'(1);
         if (miss) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q     <= '0;
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else begin
         slot_q     <= slot_d;
         br_cnt_q   <= br_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor.
// Immediate-assertion checks with a final summary line.
module tb_branch_predictor;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   branch_predictor_if #(.CNT_W(16)) bpi ();

   branch_predictor #(
      .IDX_W (4),
      .CNT_W (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bp  (bpi)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ID cycle then EX cycle for one branch; checks prediction and resolve.
   task automatic issue(input string tag, input logic [31:0] pc,
                        input logic taken, input logic exp_pred);
      bpi.id_branch = 1'b1;
      bpi.id_pc     = pc;
      bpi.id_pc_imm = pc + 32'h40;
      bpi.ex_taken  = 1'b0;
      #1;
      chk({tag, "_pred"}, 32'(bpi.branch_o), 32'(exp_pred));
      tick();
      bpi.id_branch = 1'b0;
      bpi.ex_taken  = taken;
      #1;
      chk({tag, "_miss"}, 32'(bpi.miss_o), 32'(exp_pred != taken));
      chk({tag, "_rpc"}, bpi.recover_pc_o,
          (exp_pred == taken) ? 32'h0 : (taken ? pc + 32'h40 : pc + 32'h4));
      tick();
      bpi.ex_taken = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      bpi.stall     = 1'b0;
      bpi.id_branch = 1'b0;
      bpi.id_pc     = 32'h0;
      bpi.id_pc_imm = 32'h0;
      bpi.ex_taken  = 1'b0;
      tick();
      tick();
      chk("rst_branch", 32'(bpi.branch_o), 32'h0);
      chk("rst_miss", 32'(bpi.miss_o), 32'h0);
      chk("rst_rpc", bpi.recover_pc_o, 32'h0);
      chk("rst_br", 32'(bpi.br_cnt_o), 32'h0);
      chk("rst_mc", 32'(bpi.miss_cnt_o), 32'h0);
      chk("rst_ctr0", 32'(dut.u_tbl.ctr_q[0]), 32'h1);
      chk("rst_ctr15", 32'(dut.u_tbl.ctr_q[15]), 32'h1);
      rst = 1'b0;

      // First branch: predicted NT, actually taken.
      issue("b1", 32'h100, 1'b1, 1'b0);
      chk("b1_ctr", 32'(dut.u_tbl.ctr_q[0]), 32'h2);
      chk("b1_br", 32'(bpi.br_cnt_o), 32'h1);
      chk("b1_mc", 32'(bpi.miss_cnt_o), 32'h1);
      chk("b1_idle", 32'(bpi.miss_o), 32'h0);

      // Taken three more times; saturate at 3.
      issue("t2", 32'h100, 1'b1, 1'b1);
      chk("t2_ctr", 32'(dut.u_tbl.ctr_q[0]), 32'h3);
      issue("t3", 32'h100, 1'b1, 1'b1);
      issue("t4", 32'h100, 1'b1, 1'b1);
      chk("sat_ctr", 32'(dut.u_tbl.ctr_q[0]), 32'h3);
      issue("nt", 32'h100, 1'b0, 1'b1);
      chk("nt_ctr", 32'(dut.u_tbl.ctr_q[0]), 32'h2);
      chk("nt_br", 32'(bpi.br_cnt_o), 32'h5);
      chk("nt_mc", 32'(bpi.miss_cnt_o), 32'h2);
      bpi.id_branch = 1'b1;
      bpi.id_pc     = 32'h100;
      #1;
      chk("still_t", 32'(bpi.branch_o), 32'h1);
      bpi.id_branch = 1'b0;
      #1;

      // Mispredict held in EX by a 3-cycle stall.
      bpi.id_branch = 1'b1;
      bpi.id_pc     = 32'h100;
      bpi.id_pc_imm = 32'h140;
      tick();
      bpi.id_branch = 1'b0;
      bpi.ex_taken  = 1'b0;
      bpi.stall     = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stl_miss", 32'(bpi.miss_o), 32'h1);
         chk("stl_rpc", bpi.recover_pc_o, 32'h104);
         tick();
      end
      chk("stl_ctr", 32'(dut.u_tbl.ctr_q[0]), 32'h2);
      chk("stl_mc", 32'(bpi.miss_cnt_o), 32'h2);
      bpi.stall = 1'b0;
      #1;
      chk("stl_miss4", 32'(bpi.miss_o), 32'h1);
      tick();
      chk("stl_ctr2", 32'(dut.u_tbl.ctr_q[0]), 32'h1);
      chk("stl_br", 32'(bpi.br_cnt_o), 32'h6);
      chk("stl_mc2", 32'(bpi.miss_cnt_o), 32'h3);

      // Miss in EX squashes the branch at 0x200 in ID.
      bpi.id_branch = 1'b1;
      bpi.id_pc     = 32'h100;
      bpi.id_pc_imm = 32'h140;
      tick();
      bpi.ex_taken  = 1'b1;
      bpi.id_pc     = 32'h200;
      bpi.id_pc_imm = 32'h240;
      #1;
      chk("sq_miss", 32'(bpi.miss_o), 32'h1);
      chk("sq_branch", 32'(bpi.branch_o), 32'h0);
      tick();
      bpi.id_branch = 1'b0;
      bpi.ex_taken  = 1'b0;
      #1;
      chk("sq_nomiss", 32'(bpi.miss_o), 32'h0);
      tick();
      chk("sq_br", 32'(bpi.br_cnt_o), 32'h7);
      chk("sq_mc", 32'(bpi.miss_cnt_o), 32'h4);

      // Same-index lookup and update after a fresh reset.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bpi.id_branch = 1'b1;
      bpi.id_pc     = 32'h100;
      bpi.id_pc_imm = 32'h140;
      tick();
      bpi.ex_taken  = 1'b1;
      bpi.id_pc     = 32'h140;
      bpi.id_pc_imm = 32'h180;
      #1;
      chk("hz_old", 32'(dut.u_tbl.ctr_q[0]), 32'h1);
      chk("hz_branch", 32'(bpi.branch_o), 32'h0);
      tick();
      bpi.id_branch = 1'b0;
      bpi.ex_taken  = 1'b0;
      chk("hz_new", 32'(dut.u_tbl.ctr_q[0]), 32'h2);

      // Reset with a would-be mispredict in EX.
      bpi.id_branch = 1'b1;
      bpi.id_pc     = 32'h100;
      bpi.id_pc_imm = 32'h140;
      tick();
      bpi.id_branch = 1'b0;
      bpi.ex_taken  = 1'b0;
      rst = 1'b1;
      #1;
      chk("rx_miss", 32'(bpi.miss_o), 32'h0);
      chk("rx_rpc", bpi.recover_pc_o, 32'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("rx_miss2", 32'(bpi.miss_o), 32'h0);
      chk("rx_ctr", 32'(dut.u_tbl.ctr_q[0]), 32'h1);
      chk("rx_br", 32'(bpi.br_cnt_o), 32'h0);
      chk("rx_mc", 32'(bpi.miss_cnt_o), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
